pemcu_xbus_arb: RTL and testbench

- Arbiter and sequencer for the PEMCU register target bus (F0E0–F0FC EQ regs, F9B0/F9B4 autofill regs).
- Shares the bus between two requesters:
  - the R8051XC2 external memory port (memaddr/memwr/memrd/memdatao/memdatai/memack);
  - the PCIe config-space path (CFG_WR/RNUM/WDATA/RDATA/RRDY).
- Allows one outstanding transaction at a time, uses round-robin grant, and has a target timeout so a hung target cannot stall the MCU.

---
 rtl/pemcu_xbus_arb.sv | 133 +++++++++++++
 tb/tb_pemcu_xbus_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pemcu_xbus_arb.sv
// PEMCU register-bus arbiter: MCU external port vs PCIe config path.
// Define PEMCU_XBUS_CFG_PRIO_EN for fixed CFG priority instead of round-robin.
module pemcu_xbus_arb #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] memaddr,
  input  logic          memwr,
  input  logic          memrd,
  input  logic [DW-1:0] memdatao,
  output logic [DW-1:0] memdatai,
  output logic          memack,
  input  logic          cfg_req,
  input  logic          cfg_wr,
  input  logic [AW-1:0] cfg_rnum,
  input  logic [DW-1:0] cfg_wdata,
  output logic [DW-1:0] cfg_rdata,
  output logic          cfg_rrdy,
  output logic          tgt_req,
  output logic          tgt_wr,
  output logic [AW-1:0] tgt_addr,
  output logic [DW-1:0] tgt_wdata,
  input  logic [DW-1:0] tgt_rdata,
  input  logic          tgt_ack,
  output logic          tmo_err,
  input  logic          tmo_clr,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic          last_grant;
  logic [7:0]    cnt;
  logic          mcu_req;
  logic          any_req;
  logic          pick_cfg;
  logic          tmo_hit;
  logic          done;
  logic [DW-1:0] rd_val;

  assign mcu_req = memwr | memrd;
  assign any_req = mcu_req | cfg_req;

`ifdef PEMCU_XBUS_CFG_PRIO_EN
  assign pick_cfg = cfg_req;
`else
  // last_grant == 1 means CFG went last, so MCU takes the tie
  assign pick_cfg = cfg_req & (~mcu_req | ~last_grant);
`endif

  // an ack in the final wait cycle beats the timeout
  assign tmo_hit = (state == S_WAIT) & ~tgt_ack
                 & (cnt == TMO_LAST);
  assign done    = (state == S_WAIT) & (tgt_ack | tmo_hit);
  assign rd_val  = tgt_ack ? tgt_rdata : {DW{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (done) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tgt_req  = 1'b0;
    memack   = 1'b0;
    cfg_rrdy = 1'b0;
    unique case (state)
      S_ISSUE: tgt_req = 1'b1;
      S_WAIT:  tgt_req = 1'b1;
      S_RESP: begin
        memack   = ~grant_id;
        cfg_rrdy = grant_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      tgt_wr     <= 1'b0;
      tgt_addr   <= '0;
      tgt_wdata  <= '0;
      cnt        <= '0;
      memdatai   <= '0;
      cfg_rdata  <= '0;
      tmo_err    <= 1'b0;
    end else begin
      if (state == S_IDLE && any_req) begin
        grant_id  <= pick_cfg;
        tgt_addr  <= pick_cfg ? cfg_rnum : memaddr;
        tgt_wdata <= pick_cfg ? cfg_wdata : memdatao;
        tgt_wr    <= pick_cfg ? cfg_wr : memwr;
      end
      if (state == S_ISSUE)
        cnt <= '0;
      else if (state == S_WAIT && !tgt_ack)
        cnt <= cnt + 8'd1;
      // writes leave the read port holding its last value
      if (done && !tgt_wr) begin
        if (grant_id) cfg_rdata <= rd_val;
        else          memdatai  <= rd_val;
      end
      if (state == S_RESP)
        last_grant <= grant_id;
      if (tmo_hit)      tmo_err <= 1'b1;
      else if (tmo_clr) tmo_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pemcu_xbus_arb.sv
// Scoreboard bench for pemcu_xbus_arb.
// Completions are checked by a monitor against a queue of expectations.
module tb_pemcu_xbus_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] memaddr = '0;
  logic        memwr = 1'b0;
  logic        memrd = 1'b0;
  logic [7:0]  memdatao = '0;
  logic [7:0]  memdatai;
  logic        memack;
  logic        cfg_req = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_rnum = '0;
  logic [7:0]  cfg_wdata = '0;
  logic [7:0]  cfg_rdata;
  logic        cfg_rrdy;
  logic        tgt_req;
  logic        tgt_wr;
  logic [15:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic [7:0]  tgt_rdata = '0;
  logic        tgt_ack = 1'b0;
  logic        tmo_err;
  logic        tmo_clr = 1'b0;
  logic        grant_id;

  pemcu_xbus_arb dut (
    .clk(clk), .rst_n(rst_n),
    .memaddr(memaddr), .memwr(memwr),
    .memrd(memrd), .memdatao(memdatao),
    .memdatai(memdatai), .memack(memack),
    .cfg_req(cfg_req), .cfg_wr(cfg_wr),
    .cfg_rnum(cfg_rnum), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rrdy(cfg_rrdy),
    .tgt_req(tgt_req), .tgt_wr(tgt_wr),
    .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
    .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack),
    .tmo_err(tmo_err), .tmo_clr(tmo_clr),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_rd[2];

  int          ack_delay = 0;
  bit          no_ack = 1'b0;
  bit          auto_inc = 1'b0;
  logic [7:0]  ack_data = '0;
  logic [15:0] seen_addr = '0;
  logic [7:0]  seen_wdata = '0;
  logic        seen_wr = 1'b0;

  int          mcu_left = 0;
  int          cfg_left = 0;
  int          lat = 0;
  int          req_len = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    sb.push_back(e);
    last_rd[id] = d;
  endtask

  // Target model: ack after ack_delay extra wait cycles.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      tgt_ack = 1'b0;
      if (tgt_req) begin
        k++;
        if (!no_ack && k == ack_delay + 2) begin
          tgt_ack = 1'b1;
          tgt_rdata = ack_data;
          seen_addr = tgt_addr;
          seen_wdata = tgt_wdata;
          seen_wr = tgt_wr;
          if (auto_inc) ack_data = ack_data + 8'd1;
        end
      end else begin
        k = 0;
      end
    end
  end

  // Monitor: every completion pulse pops one expectation.
  always @(negedge clk) begin
    if (memack || cfg_rrdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected memack=%0b cfg_rrdy=%0b",
                 memack, cfg_rrdy);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pulse", {memack, cfg_rrdy},
            e.id ? 2'b01 : 2'b10);
        chk("sb_grant", grant_id, e.id);
        chk("sb_data", e.id ? cfg_rdata : memdatai, e.data);
      end
    end
  end

  task automatic run(input int budget);
    int n = 0;
    lat = 0;
    req_len = 0;
    while ((mcu_left > 0 || cfg_left > 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (tgt_req) req_len++;
      if (memack && mcu_left > 0) begin
        if (lat == 0) lat = n + 1;
        mcu_left--;
        if (mcu_left == 0) begin
          memwr = 1'b0;
          memrd = 1'b0;
        end
      end
      if (cfg_rrdy && cfg_left > 0) begin
        cfg_left--;
        if (cfg_left == 0) cfg_req = 1'b0;
      end
    end
    if (mcu_left > 0 || cfg_left > 0) begin
      checks++;
      errors++;
      $display("FAIL run_budget mcu_left=%0d cfg_left=%0d",
               mcu_left, cfg_left);
      memwr = 1'b0;
      memrd = 1'b0;
      cfg_req = 1'b0;
      mcu_left = 0;
      cfg_left = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, memdatai, memack, cfg_rdata, cfg_rrdy,
            tgt_req, tgt_wr, tgt_addr, tgt_wdata,
            tmo_err, grant_id};
  endfunction

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // MCU write, ack in first wait cycle
    ack_delay = 0;
    ack_data = 8'hEE;
    memaddr = 16'hF0F4;
    memdatao = 8'h5A;
    memwr = 1'b1;
    mcu_left = 1;
    push(0, last_rd[0]);
    run(50);
    chk("wr_latency", lat, 4);
    chk("wr_addr", seen_addr, 16'hF0F4);
    chk("wr_wdata", seen_wdata, 8'h5A);
    chk("wr_wr", seen_wr, 1'b1);

    // CFG read with 5 idle wait cycles
    @(negedge clk);
    ack_delay = 5;
    ack_data = 8'h3C;
    cfg_rnum = 16'hF9B4;
    cfg_wr = 1'b0;
    cfg_req = 1'b1;
    cfg_left = 1;
    push(1, 8'h3C);
    run(50);
    chk("cfg_req_len", req_len, 7);
    chk("cfg_wr_qual", seen_wr, 1'b0);

    // Simultaneous requests held for two grants each
    do_reset();
    ack_delay = 0;
    ack_data = 8'hA1;
    auto_inc = 1'b1;
    memaddr = 16'hF0E8;
    cfg_rnum = 16'hF9B0;
    memrd = 1'b1;
    cfg_req = 1'b1;
    mcu_left = 2;
    cfg_left = 2;
`ifdef PEMCU_XBUS_CFG_PRIO_EN
    push(1, 8'hA1);
    push(1, 8'hA2);
    push(0, 8'hA3);
    push(0, 8'hA4);
`else
    push(0, 8'hA1);
    push(1, 8'hA2);
    push(0, 8'hA3);
    push(1, 8'hA4);
`endif
    run(100);
    auto_inc = 1'b0;

    // Target never answers
    @(negedge clk);
    no_ack = 1'b1;
    memaddr = 16'hF0F0;
    memrd = 1'b1;
    mcu_left = 1;
    push(0, 8'hFF);
    run(400);
    chk("tmo_req_len", req_len, 256);
    chk("tmo_err_set", tmo_err, 1'b1);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    chk("tmo_err_clr", tmo_err, 1'b0);

    // Ack lands in the timeout cycle
    @(negedge clk);
    no_ack = 1'b0;
    ack_delay = 254;
    ack_data = 8'h77;
    memrd = 1'b1;
    mcu_left = 1;
    push(0, 8'h77);
    run(400);
    chk("race_req_len", req_len, 256);
    chk("race_tmo_err", tmo_err, 1'b0);

    // Reset in the middle of a CFG write
    @(negedge clk);
    no_ack = 1'b1;
    cfg_rnum = 16'hF0FC;
    cfg_wdata = 8'h9E;
    cfg_wr = 1'b1;
    cfg_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_tgt_req", {tgt_req, grant_id}, 2'b11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", all_outs(), 64'd0);
    cfg_req = 1'b0;
    cfg_wr = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Normal MCU write after reset
    ack_delay = 0;
    memaddr = 16'hF0E0;
    memdatao = 8'h11;
    memwr = 1'b1;
    mcu_left = 1;
    push(0, last_rd[0]);
    run(50);
    chk("post_latency", lat, 4);
    chk("post_addr", seen_addr, 16'hF0E0);
    chk("post_wdata", seen_wdata, 8'h11);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
